// File: rtl/median_filter_pw.sv
// Streaming rank filter: sliding window, odd-even transposition sort,
// per-sample median/min/max select with warm-up suppression.
module median_filter_pw #(
    parameter int DW  = 8,
    parameter int WIN = 9
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] dat_i,
    input  logic          val_i,
    input  logic          sof_i,
    input  logic [1:0]    mode_i,
    output logic [DW-1:0] dat_o,
    output logic          val_o
);

    localparam int FW  = $clog2(WIN + 1);
    localparam int MID = (WIN - 1) / 2;

    typedef logic [WIN-1:0][DW-1:0] vec_t;

    typedef enum logic [1:0] {
        MD_MED = 2'd0,
        MD_MIN = 2'd1,
        MD_MAX = 2'd2,
        MD_RSV = 2'd3
    } mode_e;

    // One transposition stage: odd=0 pairs (0,1),(2,3)..; odd=1 pairs (1,2)..
    function automatic vec_t cx(input vec_t v, input logic odd);
        vec_t r;
        r = v;
        for (int k = 0; k < WIN - 1; k++) begin
            if ((k[0] == odd) && (v[k] > v[k+1])) begin
                r[k]   = v[k+1];
                r[k+1] = v[k];
            end
        end
        return r;
    endfunction

    vec_t          win_q, win_d;
    logic [FW-1:0] fill_q, fill_d;
    mode_e         md0_q, md0_d;
    logic          tag0_q, tag0_d;

    vec_t          sv_q [WIN];
    vec_t          sv_d [WIN];
    mode_e         sm_q [WIN];
    logic          st_q [WIN];

    logic [DW-1:0] sel;
    logic [DW-1:0] dat_q, dat_d;
    logic          val_q, val_d;

    // Window shift, fill tracking and snapshot tag for the accepted sample
    always_comb begin
        win_d  = win_q;
        fill_d = fill_q;
        md0_d  = md0_q;
        tag0_d = 1'b0;
        if (val_i) begin
            md0_d = mode_e'(mode_i);
            if (sof_i) begin
                win_d    = '0;
                win_d[0] = dat_i;
                fill_d   = FW'(1);
            end else begin
                for (int i = WIN - 1; i > 0; i--) begin
                    win_d[i] = win_q[i-1];
                end
                win_d[0] = dat_i;
                if (fill_q != FW'(WIN)) begin
                    fill_d = fill_q + 1'b1;
                end
            end
            tag0_d = (fill_d == FW'(WIN));
        end
    end

    // Window register doubles as the snapshot launched into the sorter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_q  <= '0;
            fill_q <= '0;
            md0_q  <= MD_MED;
            tag0_q <= 1'b0;
        end else begin
            win_q  <= win_d;
            fill_q <= fill_d;
            md0_q  <= md0_d;
            tag0_q <= tag0_d;
        end
    end

    // Compare-exchange for every sort stage
    always_comb begin
        sv_d[0] = cx(win_q, 1'b0);
        for (int s = 1; s < WIN; s++) begin
            sv_d[s] = cx(sv_q[s-1], s[0]);
        end
    end

    // Sort pipeline registers with mode and tag travelling alongside
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < WIN; s++) begin
                sv_q[s] <= '0;
                sm_q[s] <= MD_MED;
                st_q[s] <= 1'b0;
            end
        end else begin
            for (int s = 0; s < WIN; s++) begin
                sv_q[s] <= sv_d[s];
            end
            sm_q[0] <= md0_q;
            st_q[0] <= tag0_q;
            for (int s = 1; s < WIN; s++) begin
                sm_q[s] <= sm_q[s-1];
                st_q[s] <= st_q[s-1];
            end
        end
    end

    // Rank select on the ascending vector; dat holds across bubbles
    always_comb begin
        unique case (sm_q[WIN-1])
            MD_MIN:  sel = sv_q[WIN-1][0];
            MD_MAX:  sel = sv_q[WIN-1][WIN-1];
            default: sel = sv_q[WIN-1][MID];
        endcase
        dat_d = dat_q;
        if (st_q[WIN-1]) begin
            dat_d = sel;
        end
        val_d = st_q[WIN-1];
    end

    // Output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dat_q <= '0;
            val_q <= 1'b0;
        end else begin
            dat_q <= dat_d;
            val_q <= val_d;
        end
    end

    assign dat_o = dat_q;
    assign val_o = val_q;

endmodule

// File: tb/tb_median_filter_pw.sv
// Bench for median_filter_pw: directed corner cases plus random streams
// against a queue-and-sort reference model at WIN=9/DW=8, WIN=3 and WIN=15/DW=12.
module tb_median_filter_pw;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  d8;
    logic [11:0] d12;
    logic        val, sof;
    logic [1:0]  mode;
    logic [7:0]  o8;
    logic [11:0] o3, o15;
    logic        v8, v3, v15;

    always #5 clk = ~clk;

    median_filter_pw #(.DW(8), .WIN(9)) u_dut (
        .clk(clk), .rst_n(rst_n), .dat_i(d8), .val_i(val), .sof_i(sof),
        .mode_i(mode), .dat_o(o8), .val_o(v8)
    );
    median_filter_pw #(.DW(12), .WIN(3)) u_w3 (
        .clk(clk), .rst_n(rst_n), .dat_i(d12), .val_i(val), .sof_i(sof),
        .mode_i(mode), .dat_o(o3), .val_o(v3)
    );
    median_filter_pw #(.DW(12), .WIN(15)) u_w15 (
        .clk(clk), .rst_n(rst_n), .dat_i(d12), .val_i(val), .sof_i(sof),
        .mode_i(mode), .dat_o(o15), .val_o(v15)
    );

    typedef struct {
        bit          v;
        int unsigned d;
    } ev_t;

    typedef struct {
        logic [1:0] mode;
        int         gap;
        int         first;
        int         n;
    } row_t;

    int unsigned hist [3][$];
    ev_t         pipe [3][$];
    int unsigned held [3];
    int          npass = 0;
    int          ntot  = 0;
    int          cyc   = 0;
    int unsigned obs_d [$];
    int          obs_c [$];

    function automatic int wof(input int m);
        case (m)
            0:       return 9;
            1:       return 3;
            default: return 15;
        endcase
    endfunction

    function automatic int unsigned ref_rank(input int unsigned h[$], input int w,
                                             input logic [1:0] md);
        int unsigned a[$];
        int unsigned t;
        a = h;
        for (int i = 1; i < a.size(); i++) begin
            for (int j = i; j > 0; j--) begin
                if (a[j-1] <= a[j]) break;
                t = a[j]; a[j] = a[j-1]; a[j-1] = t;
            end
        end
        case (md)
            2'd1:    return a[0];
            2'd2:    return a[w-1];
            default: return a[(w-1)/2];
        endcase
    endfunction

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        ntot++;
        if (act == exp) npass++;
        else $display("FAIL %s @cyc %0d: got %0d, expected %0d", name, cyc, act, exp);
    endtask

    task automatic model_push(input int m, input bit v, input bit s,
                              input logic [1:0] md, input int unsigned dat);
        ev_t e;
        e.v = 1'b0;
        e.d = 0;
        if (v) begin
            if (s) hist[m].delete();
            hist[m].push_back(dat);
            if (hist[m].size() > wof(m)) hist[m].delete(0);
            if (hist[m].size() == wof(m)) begin
                e.v = 1'b1;
                e.d = ref_rank(hist[m], wof(m), md);
            end
        end
        pipe[m].push_back(e);
    endtask

    task automatic check_all();
        ev_t         e;
        bit          vo;
        int unsigned dout;
        for (int m = 0; m < 3; m++) begin
            case (m)
                0:       begin vo = v8;  dout = o8;  end
                1:       begin vo = v3;  dout = o3;  end
                default: begin vo = v15; dout = o15; end
            endcase
            e.v = 1'b0;
            e.d = 0;
            if (pipe[m].size() >= wof(m) + 2) e = pipe[m].pop_front();
            if (e.v) held[m] = e.d;
            chk($sformatf("val_o[w%0d]", wof(m)), vo, e.v);
            chk($sformatf("dat_o[w%0d]", wof(m)), dout, held[m]);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        check_all();
        if (v8) begin
            obs_d.push_back(o8);
            obs_c.push_back(cyc);
        end
    endtask

    task automatic cyc_in(input bit v, input bit s, input logic [1:0] md,
                          input int unsigned a8, input int unsigned a12);
        val  = v;
        sof  = s;
        mode = md;
        d8   = a8[7:0];
        d12  = a12[11:0];
        model_push(0, v, s, md, a8 & 32'hFF);
        model_push(1, v, s, md, a12 & 32'hFFF);
        model_push(2, v, s, md, a12 & 32'hFFF);
        step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc_in(1'b0, 1'b0, 2'd0, 0, 0);
    endtask

    task automatic clear_model();
        for (int m = 0; m < 3; m++) begin
            hist[m].delete();
            pipe[m].delete();
            held[m] = 0;
        end
    endtask

    row_t tbl [6];
    int   c9, c9b;
    int unsigned ex;
    int unsigned r;
    bit   rv, rs;
    int unsigned a8, a12;

    initial begin
        tbl[0] = '{mode: 2'd0, gap: 0, first: 5, n: 7};
        tbl[1] = '{mode: 2'd1, gap: 0, first: 1, n: 7};
        tbl[2] = '{mode: 2'd2, gap: 0, first: 9, n: 7};
        tbl[3] = '{mode: 2'd0, gap: 1, first: 5, n: 7};
        tbl[4] = '{mode: 2'd1, gap: 1, first: 1, n: 7};
        tbl[5] = '{mode: 2'd2, gap: 1, first: 9, n: 7};

        rst_n = 1'b0;
        val = 1'b0; sof = 1'b0; mode = 2'd0; d8 = '0; d12 = '0;
        clear_model();
        idle(3);
        rst_n = 1'b1;
        idle(2);

        // impulse rejection and warm-up
        obs_d.delete(); obs_c.delete();
        c9 = 0;
        for (int i = 1; i <= 20; i++) begin
            if (i == 9) c9 = cyc;
            cyc_in(1'b1, 1'b0, 2'd0, (i == 12) ? 200 : 10, (i == 12) ? 200 : 10);
        end
        idle(14);
        chk("imp_count", obs_d.size(), 12);
        if (obs_c.size() > 0) chk("imp_first_cyc", obs_c[0], c9 + 11);
        foreach (obs_d[j]) chk("imp_val", obs_d[j], 10);

        // ramp with fixed mode, contiguous and with bubbles
        foreach (tbl[t]) begin
            obs_d.delete(); obs_c.delete();
            for (int i = 1; i <= 15; i++) begin
                if (i == 9) c9 = cyc;
                cyc_in(1'b1, i == 1, tbl[t].mode, i, i);
                idle(tbl[t].gap);
            end
            idle(14);
            chk($sformatf("ramp%0d_count", t), obs_d.size(), tbl[t].n);
            if (obs_c.size() > 0) chk($sformatf("ramp%0d_first", t), obs_c[0], c9 + 11);
            foreach (obs_d[j]) begin
                chk($sformatf("ramp%0d_val", t), obs_d[j], tbl[t].first + j);
                if (j > 0) chk($sformatf("ramp%0d_gap", t), obs_c[j] - obs_c[j-1], tbl[t].gap + 1);
            end
        end

        // ramp with mode toggling every sample
        obs_d.delete(); obs_c.delete();
        for (int i = 1; i <= 15; i++) cyc_in(1'b1, i == 1, 2'(i % 3), i, i);
        idle(14);
        chk("tog_count", obs_d.size(), 7);
        foreach (obs_d[j]) begin
            case ((j + 9) % 3)
                0:       ex = j + 9 - 4;
                1:       ex = j + 9 - 8;
                default: ex = j + 9;
            endcase
            chk("tog_val", obs_d[j], ex);
        end

        // sof restart between two frames
        obs_d.delete(); obs_c.delete();
        for (int i = 1; i <= 12; i++) cyc_in(1'b1, i == 1, 2'd0, 50, 50);
        idle(2);
        c9b = 0;
        for (int i = 1; i <= 12; i++) begin
            if (i == 9) c9b = cyc;
            cyc_in(1'b1, i == 1, 2'd0, 100, 100);
        end
        idle(14);
        chk("sof_count", obs_d.size(), 8);
        foreach (obs_d[j]) chk("sof_val", obs_d[j], (j < 4) ? 50 : 100);
        if (obs_c.size() > 4) chk("sof_b_first", obs_c[4], c9b + 11);

        // asynchronous reset with results in flight
        obs_d.delete(); obs_c.delete();
        for (int i = 1; i <= 13; i++) cyc_in(1'b1, i == 1, 2'd0, 20 + i, 20 + i);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_dat8", o8, 0);
        chk("rst_val8", v8, 0);
        chk("rst_dat3", o3, 0);
        chk("rst_val15", v15, 0);
        clear_model();
        idle(3);
        rst_n = 1'b1;
        idle(14);
        chk("rst_no_stale", obs_d.size(), 0);
        for (int i = 1; i <= 12; i++) begin
            if (i == 9) c9 = cyc;
            cyc_in(1'b1, 1'b0, 2'd0, 77, 77);
        end
        idle(14);
        chk("rst_warm_count", obs_d.size(), 4);
        if (obs_c.size() > 0) chk("rst_warm_first", obs_c[0], c9 + 11);
        foreach (obs_d[j]) chk("rst_warm_val", obs_d[j], 77);

        // random streams against the reference model on all three instances
        for (int i = 0; i < 3000; i++) begin
            rv = ($urandom_range(9) < 7);
            rs = rv && ($urandom_range(49) == 0);
            r  = $urandom_range(9);
            a8  = (r == 0) ? 255 : (r == 1) ? 0 : $urandom_range(255);
            r  = $urandom_range(9);
            a12 = (r == 0) ? 4095 : (r == 1) ? 0 : $urandom_range(4095);
            cyc_in(rv, rs, 2'($urandom_range(3)), a8, a12);
        end
        idle(20);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
